axi_write: RTL



---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_write_if.sv | 45 ++++
 rtl/axi_burst_split.sv | 58 +++++
 rtl/axi_write.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI helpers and constants for the read and write masters.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_CALC0,
        WR_CALC1,
        WR_AW,
        WR_W,
        WR_B
    } axi_wr_state_e;

    function automatic int unsigned CLOG2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 1;
        end
        return result;
    endfunction

    // AxSIZE encoding for a beat of the given byte count
    function automatic logic [2:0] axi_size(input int unsigned bytes);
        return 3'(CLOG2(bytes));
    endfunction

endpackage

// File: rtl/axi_write_if.sv
// AXI write-channel bundle (AW, W, B) between a write master and the interconnect.
interface axi_write_if #(
    parameter int unsigned AXI_ID_BITWIDTH   = 4,
    parameter int unsigned AXI_ADDR_BITWIDTH = 30,
    parameter int unsigned AXI_LEN_BITWIDTH  = 8,
    parameter int unsigned AXI_DATA_BITWIDTH = 128
);
    localparam int unsigned STRB_W = AXI_DATA_BITWIDTH / 8;

    logic [AXI_ID_BITWIDTH-1:0]   m_axi_awid;
    logic [AXI_ADDR_BITWIDTH-1:0] m_axi_awaddr;
    logic [AXI_LEN_BITWIDTH-1:0]  m_axi_awlen;
    logic [2:0]                   m_axi_awsize;
    logic [1:0]                   m_axi_awburst;
    logic                         m_axi_awlock;
    logic [3:0]                   m_axi_awcache;
    logic [2:0]                   m_axi_awprot;
    logic [3:0]                   m_axi_awqos;
    logic                         m_axi_awvalid;
    logic                         m_axi_awready;
    logic [AXI_DATA_BITWIDTH-1:0] m_axi_wdata;
    logic [STRB_W-1:0]            m_axi_wstrb;
    logic                         m_axi_wlast;
    logic                         m_axi_wvalid;
    logic                         m_axi_wready;
    logic [AXI_ID_BITWIDTH-1:0]   m_axi_bid;
    logic [1:0]                   m_axi_bresp;
    logic                         m_axi_bvalid;
    logic                         m_axi_bready;

    modport master (
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        input  m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

    modport slave (
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
               m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awvalid,
               m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid, m_axi_bready,
        output m_axi_awready, m_axi_wready, m_axi_bid, m_axi_bresp, m_axi_bvalid
    );

endinterface

// File: rtl/axi_burst_split.sv
// Two-cycle burst sizing: distance to the next LIMIT-beat boundary, then clipped by
// the remaining length. Shared by the read and write masters.
module axi_burst_split
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned LIMIT  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     calc0_i,
    input  logic                     calc1_i,
    input  logic [CLOG2(LIMIT)-1:0]  beat_off_i,
    input  logic [ADDR_W-1:0]        remaining_i,
    output logic [LEN_W:0]           blen_o,
    output logic [LEN_W-1:0]         awlen_o
);
    localparam int unsigned BLEN_W = LEN_W + 1;

    logic [BLEN_W-1:0] delta_q, delta_d;
    logic [BLEN_W-1:0] blen_q,  blen_d;
    logic [LEN_W-1:0]  awlen_q, awlen_d;

    // LIMIT is a power of two, so the beat offset within a window is a bit slice
    always_comb begin
        delta_d = delta_q;
        blen_d  = blen_q;
        awlen_d = awlen_q;
        if (calc0_i) begin
            delta_d = BLEN_W'(LIMIT) - BLEN_W'(beat_off_i);
        end
        if (calc1_i) begin
            if (ADDR_W'(delta_q) < remaining_i) begin
                blen_d = delta_q;
            end else begin
                blen_d = BLEN_W'(remaining_i);
            end
            awlen_d = LEN_W'(blen_d - BLEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delta_q <= '0;
            blen_q  <= '0;
            awlen_q <= '0;
        end else begin
            delta_q <= delta_d;
            blen_q  <= blen_d;
            awlen_q <= awlen_d;
        end
    end

    assign blen_o  = blen_q;
    assign awlen_o = awlen_q;

endmodule

// File: rtl/axi_write.sv
// AXI write master: splits a (address, beats) command into INCR bursts at BURST_MAX
// and 4 KB boundaries, streaming unbuffered input beats onto the W channel.
module axi_write
    import axi_pkg::*;
#(
    parameter int unsigned AXI_ID_BITWIDTH   = 4,
    parameter int unsigned AXI_ADDR_BITWIDTH = 30,
    parameter int unsigned AXI_LEN_BITWIDTH  = 8,
    parameter int unsigned AXI_DATA_BITWIDTH = 128,
    parameter int unsigned AXI_STRB_BITWIDTH = AXI_DATA_BITWIDTH / 8,
    parameter int unsigned BURST_MAX         = 256,
    parameter int unsigned ID                = 0
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    output logic                          write_cmd_done,
    input  logic                          write_cmd_start,
    input  logic [AXI_ADDR_BITWIDTH-1:0]  write_cmd_addr,
    input  logic [AXI_ADDR_BITWIDTH-1:0]  write_cmd_len,
    output logic                          write_cmd_err,
    input  logic                          write_axis_valid,
    output logic                          write_axis_ready,
    input  logic [AXI_DATA_BITWIDTH-1:0]  write_axis_data,
    axi_write_if.master                   m_axi
);
    localparam int unsigned ADDR_W   = AXI_ADDR_BITWIDTH;
    localparam int unsigned BLEN_W   = AXI_LEN_BITWIDTH + 1;
    localparam int unsigned BYTES    = AXI_DATA_BITWIDTH / 8;
    localparam int unsigned SIZE_W   = CLOG2(BYTES);
    localparam int unsigned LIMIT_4K = 4096 / BYTES;
    localparam int unsigned LIMIT    = (BURST_MAX < LIMIT_4K) ? BURST_MAX : LIMIT_4K;
    localparam int unsigned OFF_W    = CLOG2(LIMIT);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(BYTES - 1);

    axi_wr_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [BLEN_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              done_q, awvalid_q, bready_q;
    logic              calc0, calc1;
    logic [BLEN_W-1:0] blen;
    logic [AXI_LEN_BITWIDTH-1:0] awlen;
    logic              in_w, last_beat, w_hs;

    axi_burst_split #(
        .ADDR_W (ADDR_W),
        .LEN_W  (AXI_LEN_BITWIDTH),
        .LIMIT  (LIMIT)
    ) u_split (
        .clk         (sys_clk),
        .rst_n       (sys_rst_n),
        .calc0_i     (calc0),
        .calc1_i     (calc1),
        .beat_off_i  (addr_q[SIZE_W +: OFF_W]),
        .remaining_i (rem_q),
        .blen_o      (blen),
        .awlen_o     (awlen)
    );

    assign in_w      = (state_q == WR_W);
    assign last_beat = (cnt_q == blen - BLEN_W'(1));
    assign w_hs      = in_w && write_axis_valid && m_axi.m_axi_wready;

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        calc0   = 1'b0;
        calc1   = 1'b0;
        unique case (state_q)
            WR_IDLE: begin
                if (write_cmd_start) begin
                    addr_d  = write_cmd_addr & ~ADDR_MASK;
                    rem_d   = write_cmd_len;
                    err_d   = 1'b0;
                    state_d = WR_CALC0;
                end
            end
            WR_CALC0: begin
                calc0   = 1'b1;
                state_d = (rem_q == '0) ? WR_IDLE : WR_CALC1;
            end
            WR_CALC1: begin
                calc1   = 1'b1;
                state_d = WR_AW;
            end
            WR_AW: begin
                cnt_d = '0;
                if (m_axi.m_axi_awready) begin
                    state_d = WR_W;
                end
            end
            WR_W: begin
                if (w_hs) begin
                    cnt_d = cnt_q + BLEN_W'(1);
                    if (last_beat) begin
                        state_d = WR_B;
                    end
                end
            end
            WR_B: begin
                if (m_axi.m_axi_bvalid) begin
                    err_d   = err_q | (m_axi.m_axi_bresp != AXI_RESP_OKAY);
                    addr_d  = addr_q + (ADDR_W'(blen) << SIZE_W);
                    rem_d   = rem_q - ADDR_W'(blen);
                    state_d = WR_CALC0;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= WR_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b1;
            awvalid_q <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            done_q    <= (state_d == WR_IDLE);
            awvalid_q <= (state_d == WR_AW);
            bready_q  <= (state_d == WR_B);
        end
    end

    assign write_cmd_done   = done_q;
    assign write_cmd_err    = err_q;
    assign write_axis_ready = in_w && m_axi.m_axi_wready;

    assign m_axi.m_axi_awid    = AXI_ID_BITWIDTH'(ID);
    assign m_axi.m_axi_awaddr  = addr_q;
    assign m_axi.m_axi_awlen   = awlen;
    assign m_axi.m_axi_awsize  = axi_size(BYTES);
    assign m_axi.m_axi_awburst = AXI_BURST_INCR;
    assign m_axi.m_axi_awlock  = 1'b0;
    assign m_axi.m_axi_awcache = AXI_CACHE_DEFAULT;
    assign m_axi.m_axi_awprot  = 3'b000;
    assign m_axi.m_axi_awqos   = 4'b0000;
    assign m_axi.m_axi_awvalid = awvalid_q;
    // W follows the input stream directly; nothing is buffered
    assign m_axi.m_axi_wdata   = write_axis_data;
    assign m_axi.m_axi_wstrb   = {AXI_STRB_BITWIDTH{1'b1}};
    assign m_axi.m_axi_wvalid  = in_w && write_axis_valid;
    assign m_axi.m_axi_wlast   = in_w && last_beat;
    assign m_axi.m_axi_bready  = bready_q;

endmodule
